// File: rtl/uart_tx_if.sv
// uart_tx_if: transmit-side bundle between the core and the UART transmitter.
// The core (master) drives the strobe and byte; the transmitter (slave) drives
// the serial line and the status flags back.
interface uart_tx_if;
    logic       tx_ready;
    logic [7:0] sdata;
    logic       txd;
    logic       busy;
    logic       fifo_full;
    logic       overflow;

    modport master (
        output tx_ready,
        output sdata,
        input  txd,
        input  busy,
        input  fifo_full,
        input  overflow
    );

    modport slave (
        input  tx_ready,
        input  sdata,
        output txd,
        output busy,
        output fifo_full,
        output overflow
    );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: byte-oriented UART transmitter with a burst-absorbing FIFO.
// Serialises each queued byte as 8N1, LSB first, idle-high line.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// after the data bits (8E1, 11 bit periods per frame).
module uart_tx #(
    parameter int CLK_PER_BIT = 868,
    parameter int FIFO_AW     = 4
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave bus
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CNT_W = (CLK_PER_BIT > 2) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]   BAUD_LAST = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [FIFO_AW:0]   CNT_FULL  = (FIFO_AW+1)'(DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;
`endif

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   baud_q;
    logic [2:0]         bit_idx_q;
    logic [7:0]         shreg_q;
    logic               parity_q;
    logic               txd_q;
    logic               txd_d;
    logic               overflow_q;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] rptr_q;
    logic [FIFO_AW-1:0] wptr_q;
    logic [FIFO_AW:0]   count_q;

    logic               fifo_nonempty;
    logic               fifo_is_full;
    logic               bit_end;
    logic               pop;
    logic               push;
    logic               shift_data;
    logic               baud_clr;
    logic [7:0]         head_byte;

    assign fifo_nonempty = (count_q != '0);
    assign fifo_is_full  = (count_q == CNT_FULL);
    assign bit_end       = (baud_q == BAUD_LAST);
    assign head_byte     = mem[rptr_q];

    // A strobe is taken when there is room, or when a pop frees a slot on the same edge.
    assign push = bus.tx_ready && (!fifo_is_full || pop);

    assign bus.txd       = txd_q;
    assign bus.busy      = (state_q != S_IDLE) || fifo_nonempty;
    assign bus.fifo_full = fifo_is_full;
    assign bus.overflow  = overflow_q;

    // Line FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, next line level, FIFO pop and baud-counter control.
    always_comb begin
        state_d    = state_q;
        txd_d      = txd_q;
        pop        = 1'b0;
        shift_data = 1'b0;
        baud_clr   = 1'b0;
        case (state_q)
            S_IDLE: begin
                txd_d    = 1'b1;
                baud_clr = 1'b1;
                if (fifo_nonempty) begin
                    pop     = 1'b1;
                    txd_d   = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    txd_d   = shreg_q[0];
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        txd_d   = parity_q;
                        state_d = S_PARITY;
`else
                        txd_d   = 1'b1;
                        state_d = S_STOP;
`endif
                    end else begin
                        shift_data = 1'b1;
                        txd_d      = shreg_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    txd_d   = 1'b1;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    // Chain straight into the next frame so back-to-back bytes leave no idle gap.
                    if (fifo_nonempty) begin
                        pop     = 1'b1;
                        txd_d   = 1'b0;
                        state_d = S_START;
                    end else begin
                        txd_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                txd_d   = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered serial line, baud counter, bit index and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            txd_q      <= 1'b1;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            txd_q <= txd_d;
            if (baud_clr || bit_end) begin
                baud_q <= '0;
            end else begin
                baud_q <= baud_q + CNT_W'(1);
            end
            if (pop) begin
                bit_idx_q <= '0;
            end else if (shift_data) begin
                bit_idx_q <= bit_idx_q + 3'd1;
            end
            if (bus.tx_ready && fifo_is_full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Shift register and parity of the byte in flight; loaded on every pop.
    always_ff @(posedge clk) begin
        if (pop) begin
            shreg_q  <= head_byte;
            parity_q <= ^head_byte;
        end else if (shift_data) begin
            shreg_q <= {1'b0, shreg_q[7:1]};
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (pop) begin
                rptr_q <= rptr_q + FIFO_AW'(1);
            end
            if (push) begin
                wptr_q <= wptr_q + FIFO_AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (FIFO_AW+1)'(1);
                2'b01:   count_q <= count_q - (FIFO_AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage; contents need no reset since the count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= bus.sdata;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx at CLK_PER_BIT=4, FIFO_AW=4, with a
// queue-based reference model of the line compared every cycle, plus literal
// expectations for frame bits, FIFO-full/overflow timing and reset behaviour.
// Honours UART_TX_PARITY_EN the same way as the design.
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_tx_if bus();

    uart_tx #(
        .CLK_PER_BIT (CPB),
        .FIFO_AW     (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_fifo[$];
    logic       m_line[$];
    logic       m_txd = 1'b1;
    logic       m_busy = 1'b0;
    logic       m_ovf = 1'b0;
    logic [7:0] m_b;
    logic       m_bits[NB];
    bit         chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_fifo.delete();
            m_line.delete();
            m_txd  = 1'b1;
            m_busy = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            // A new frame starts whenever the previous one has fully played out.
            if (m_fifo.size() != 0 && m_line.size() == 0) begin
                m_b = m_fifo.pop_front();
                m_bits[0] = 1'b0;
                for (int i = 0; i < 8; i++) m_bits[i+1] = m_b[i];
`ifdef UART_TX_PARITY_EN
                m_bits[9] = ^m_b;
`endif
                m_bits[NB-1] = 1'b1;
                for (int i = 0; i < NB; i++)
                    for (int j = 0; j < CPB; j++) m_line.push_back(m_bits[i]);
            end
            if (bus.tx_ready) begin
                if (m_fifo.size() < DEPTH) m_fifo.push_back(bus.sdata);
                else m_ovf = 1'b1;
            end
            if (m_line.size() != 0) begin
                m_txd  = m_line.pop_front();
                m_busy = 1'b1;
            end else begin
                m_txd  = 1'b1;
                m_busy = 1'b0;
            end
            if (m_fifo.size() != 0) m_busy = 1'b1;
        end
    end

    // Continuous compare against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("mdl_txd", 32'(bus.txd), 32'(m_txd));
            check("mdl_busy", 32'(bus.busy), 32'(m_busy));
            check("mdl_full", 32'(bus.fifo_full), 32'(m_fifo.size() == DEPTH));
            check("mdl_ovf", 32'(bus.overflow), 32'(m_ovf));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while (bus.busy && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", 32'(bus.busy), 32'd0);
    endtask

    // Strobe one byte while idle and check every bit of the frame against a literal.
    task automatic send_and_check(input logic [7:0] b, input logic [10:0] frame, input string tag);
        bus.tx_ready = 1'b1;
        bus.sdata    = b;
        @(negedge clk);
        bus.tx_ready = 1'b0;
        check({tag, "_pre_start"}, 32'(bus.txd), 32'd1);
        for (int i = 0; i < NB; i++) begin
            for (int j = 0; j < CPB; j++) begin
                @(negedge clk);
                if (j == 1) check({tag, "_bit"}, 32'(bus.txd), 32'(frame[i]));
            end
        end
        check({tag, "_busy_last"}, 32'(bus.busy), 32'd1);
        @(negedge clk);
        check({tag, "_busy_drop"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int zeros;

    initial begin
        bus.tx_ready = 1'b0;
        bus.sdata    = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset state
        check("rst_txd", 32'(bus.txd), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_full", 32'(bus.fifo_full), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        @(negedge clk);

        // Single frames
`ifdef UART_TX_PARITY_EN
        send_and_check(8'h41, 11'h482, "f41");
        send_and_check(8'h07, 11'h60E, "f07");
`else
        send_and_check(8'h41, 11'h282, "f41");
        send_and_check(8'h07, 11'h20E, "f07");
`endif

        // Three back-to-back bytes: contiguous frames, busy never drops
        bus.tx_ready = 1'b1; bus.sdata = 8'h55; @(negedge clk);
        bus.sdata = 8'hAA; @(negedge clk);
        bus.sdata = 8'h00; @(negedge clk);
        bus.tx_ready = 1'b0;
        zeros = 0;
        for (int k = 3; k <= 3 * NB * CPB; k++) begin
            @(negedge clk);
            if (!bus.busy) zeros++;
            if (k == NB * CPB) check("b2b_stop1", 32'(bus.txd), 32'd1);
            if (k == NB * CPB + 1) check("b2b_start2", 32'(bus.txd), 32'd0);
        end
        check("b2b_busy_gaps", 32'(zeros), 32'd0);
        @(negedge clk);
        check("b2b_busy_end", 32'(bus.busy), 32'd0);
        wait_idle(10);

        // 18 consecutive strobes: fill, then drop byte 17
        for (int i = 0; i < 18; i++) begin
            bus.tx_ready = 1'b1;
            bus.sdata    = 8'(i);
            @(negedge clk);
            if (i == 15) check("fill_full15", 32'(bus.fifo_full), 32'd0);
            if (i == 16) check("fill_full16", 32'(bus.fifo_full), 32'd1);
            if (i == 16) check("fill_ovf16", 32'(bus.overflow), 32'd0);
            if (i == 17) check("fill_ovf17", 32'(bus.overflow), 32'd1);
        end
        bus.tx_ready = 1'b0;
        wait_idle(20 * NB * CPB);
        check("fill_ovf_sticky", 32'(bus.overflow), 32'd1);
        do_reset();
        check("ovf_cleared", 32'(bus.overflow), 32'd0);

        // Full FIFO plus a strobe landing on the pop edge
        for (int i = 0; i < 17; i++) begin
            bus.tx_ready = 1'b1;
            bus.sdata    = 8'(8'h80 + i);
            @(negedge clk);
        end
        bus.tx_ready = 1'b0;
        check("pop_full_before", 32'(bus.fifo_full), 32'd1);
        for (int k = 0; k < NB * CPB - 16; k++) @(negedge clk);
        bus.tx_ready = 1'b1;
        bus.sdata    = 8'hC3;
        @(negedge clk);
        bus.tx_ready = 1'b0;
        check("pop_full_after", 32'(bus.fifo_full), 32'd1);
        check("pop_full_ovf", 32'(bus.overflow), 32'd0);
        wait_idle(20 * NB * CPB);
        check("pop_full_ovf_end", 32'(bus.overflow), 32'd0);

        // Reset mid-DATA of 0x3C with five bytes queued; strobe on the reset edge
        for (int i = 0; i < 6; i++) begin
            bus.tx_ready = 1'b1;
            bus.sdata    = (i == 0) ? 8'h3C : 8'(8'h10 + i);
            @(negedge clk);
        end
        bus.tx_ready = 1'b0;
        for (int k = 0; k < 10; k++) @(negedge clk);
        rst          = 1'b1;
        bus.tx_ready = 1'b1;
        bus.sdata    = 8'hEE;
        @(negedge clk);
        rst          = 1'b0;
        bus.tx_ready = 1'b0;
        check("mid_rst_txd", 32'(bus.txd), 32'd1);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_ovf", 32'(bus.overflow), 32'd0);
        zeros = 0;
        for (int k = 0; k < 3 * NB * CPB; k++) begin
            @(negedge clk);
            if (!bus.txd || bus.busy) zeros++;
        end
        check("mid_rst_quiet", 32'(zeros), 32'd0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
